// File: rtl/instr_fetch.sv
// IF stage: PC register, IF/ID pipeline register and ID-stage branch/jump resolution.
// One-edge fetch, a taken transfer costs one bubble; stall_i freezes PC, IF/ID and the redirect counter.
module instr_fetch (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [2:0]  branch_type_i,
  input  logic        jump_i,
  input  logic        jr_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  input  logic [31:0] imm_sext_i,
  output logic [31:0] id_instr_o,
  output logic [5:0]  instr_op_o,
  output logic [31:0] id_pc4_o,
  output logic        id_valid_o,
  output logic        redirect_o,
  output logic [15:0] redirect_cnt_o
);

  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLE  = 3'd3;
  localparam logic [2:0] BR_BLT  = 3'd4;
  localparam logic [2:0] BR_BNEZ = 3'd5;

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        id_valid_q, id_valid_d;
  logic [15:0] redirect_cnt_q, redirect_cnt_d;

  logic        taken;
  logic        redirect;
  logic [31:0] pc_plus4;
  logic [31:0] target;

  // Branch condition on the ID-stage operands, signed compares.
  always_comb begin
    taken = 1'b0;
    case (branch_type_i)
      BR_BEQ:  taken = (rs_data_i == rt_data_i);
      BR_BNE:  taken = (rs_data_i != rt_data_i);
      BR_BLE:  taken = ($signed(rs_data_i) <= $signed(rt_data_i));
      BR_BLT:  taken = ($signed(rs_data_i) <  $signed(rt_data_i));
      BR_BNEZ: taken = (rs_data_i != 32'd0);
      default: taken = 1'b0;
    endcase
  end

  // A bubble in ID never redirects, whatever the decode inputs say.
  assign redirect = id_valid_q & ~stall_i & (jr_i | jump_i | (branch_i & taken));

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    target = id_pc4_q + (imm_sext_i << 2);
    if (jr_i) begin
      target = rs_data_i;
    end else if (jump_i) begin
      target = {id_pc4_q[31:28], id_instr_q[25:0], 2'b00};
    end
  end

  always_comb begin
    pc_d           = pc_q;
    id_instr_d     = id_instr_q;
    id_pc4_d       = id_pc4_q;
    id_valid_d     = id_valid_q;
    redirect_cnt_d = redirect_cnt_q;
    if (!stall_i) begin
      if (redirect) begin
        // The wrong-path word fetched this cycle is squashed into a NOP bubble.
        pc_d       = target;
        id_instr_d = 32'd0;
        id_pc4_d   = 32'd0;
        id_valid_d = 1'b0;
        if (redirect_cnt_q != 16'hFFFF) begin
          redirect_cnt_d = redirect_cnt_q + 16'd1;
        end
      end else begin
        pc_d       = pc_plus4;
        id_instr_d = imem_data_i;
        id_pc4_d   = pc_plus4;
        id_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q           <= 32'd0;
      id_instr_q     <= 32'd0;
      id_pc4_q       <= 32'd0;
      id_valid_q     <= 1'b0;
      redirect_cnt_q <= 16'd0;
    end else begin
      pc_q           <= pc_d;
      id_instr_q     <= id_instr_d;
      id_pc4_q       <= id_pc4_d;
      id_valid_q     <= id_valid_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign imem_addr_o    = pc_q;
  assign id_instr_o     = id_instr_q;
  assign instr_op_o     = id_instr_q[31:26];
  assign id_pc4_o       = id_pc4_q;
  assign id_valid_o     = id_valid_q;
  assign redirect_o     = redirect;
  assign redirect_cnt_o = redirect_cnt_q;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have one clock, clk_i, and its reset SHALL be asynchronous and active-low, named rst_i.
REQ-002 clk_i  input  1  clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  asynchronous active-low reset.
REQ-004 imem_addr_o  output  32  fetch address, equal to the current PC.
REQ-005 imem_data_i  input  32  instruction word, combinational read of imem_addr_o.
REQ-006 stall_i  input  1  hold request from hazard logic: freeze PC and IF/ID.
REQ-007 branch_i  input  1  decoder Branch for the instruction in ID.
REQ-008 branch_type_i  input  3  codes: 1 BEQ, 2 BNE, 3 BLE, 4 BLT, 5 BNEZ; other codes mean not taken.
REQ-009 jump_i  input  1  decoder Jump (j/jal) for the instruction in ID.
REQ-010 jr_i  input  1  jump-register for the instruction in ID.
REQ-011 rs_data_i, rt_data_i  input  32 each  register operands of the instruction in ID.
REQ-012 imm_sext_i  input  32  sign-extended 16-bit immediate of the instruction in ID.
REQ-013 id_instr_o  output  32  IF/ID instruction register.
REQ-014 instr_op_o  output  6  id_instr_o[31:26], driven to the decoder opcode input.
REQ-015 id_pc4_o  output  32  IF/ID register holding PC+4 of the instruction in ID.
REQ-016 id_valid_o  output  1  IF/ID holds a real instruction, not a bubble.
REQ-017 redirect_o  output  1  combinational: a taken control transfer is resolved this cycle.
REQ-018 redirect_cnt_o  output  16  saturating count of redirects.

Function
REQ-019 Taken is evaluated with signed compare:
  - type 1: rs==rt
  - type 2: rs!=rt
  - type 3: rs<=rt
  - type 4: rs<rt
  - type 5: rs!=0
REQ-020 redirect_o SHALL be id_valid_o AND NOT stall_i AND (jr_i OR jump_i OR (branch_i AND taken)).
REQ-021 Target priority SHALL be jr_i > jump_i > branch, with these targets:
  - jr: rs_data_i
  - jump: {id_pc4_o[31:28], id_instr_o[25:0], 2'b00}
  - branch: id_pc4_o + (imm_sext_i<<2)
REQ-022 All PC and target arithmetic SHALL be 32-bit modulo, so 0xFFFFFFFC+4 wraps to 0.
REQ-023 When stall_i=1, the PC, IF/ID registers and counter SHALL hold, and no redirect SHALL occur.
REQ-024 On a redirect cycle, the PC SHALL load the target. IF/ID SHALL be flushed: id_instr_o=0 (NOP), id_valid_o=0, id_pc4_o=0.
REQ-025 In all other cycles, the PC SHALL load PC+4. IF/ID SHALL capture imem_data_i, PC+4 and valid=1.
REQ-026 Control latency: a taken transfer in ID costs exactly one bubble, and the target instruction is in ID two edges after the resolving instruction entered ID.
REQ-027 A bubble (id_valid_o=0) SHALL never redirect, even if the decode inputs assert control signals.
REQ-028 redirect_cnt_o SHALL increment on each redirect edge and saturate at 0xFFFF.

Reset
REQ-029 While rst_i=0, the following SHALL hold:
  - PC=0
  - id_instr_o=0, id_pc4_o=0, id_valid_o=0
  - redirect_cnt_o=0
REQ-030 Reset asserted mid-operation, including during a stall or redirect, SHALL take effect immediately without waiting for a clock edge.
REQ-031 After rst_i rises, the first edge SHALL fetch address 0 into IF/ID with id_valid_o=1.

Verification
REQ-032 Reset release, no stall, 3 edges -> imem_addr_o 0,4,8,12; id_pc4_o 4,8,12; id_valid_o=1 from the first edge.
REQ-033 Instruction at 0x10 is BEQ with rs=rt=5, imm=3, in ID -> redirect_o=1, next PC 0x20, id_valid_o=0 for one cycle, redirect_cnt_o=1.
REQ-034 BLT with rs=-1 (0xFFFFFFFF) and rt=0 -> taken; the same instruction with type 3 and rs=1, rt=0 -> not taken, PC+4.
REQ-035 stall_i=1 for 2 cycles with jump_i=1 in ID -> PC and IF/ID unchanged and no redirect; on stall release the jump is taken to {pc4[31:28], index, 00}.
REQ-036 jr_i=1 and jump_i=1 together with rs=0x400 -> PC=0x400.
REQ-037 rst_i pulled low between edges during a redirect -> all outputs go to reset values at once; 65536 forced redirects -> redirect_cnt_o holds at 0xFFFF.
